// File: rtl/psum_row_pkg.sv
// Shared types and constants for the psum row collector.
package psum_row_pkg;
  localparam int PSUM_W_DEF = 40;
  localparam int ROWS_W     = 16;

  typedef logic [PSUM_W_DEF-1:0] psum_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } row_state_t;
endpackage

// File: rtl/psum_row_collector_if.sv
// Row write port towards the psum interconnect.
interface psum_row_collector_if #(
  parameter int PU_ROW_LEN = 16,
  parameter int PSUM_W     = 40
);
  logic [PSUM_W-1:0]     writedata [PU_ROW_LEN];
  logic                  cs;
  logic [PU_ROW_LEN-1:0] wordenable;
  logic                  waitreq;

  modport master (output writedata, output cs, output wordenable, input waitreq);
  modport slave  (input writedata, input cs, input wordenable, output waitreq);
endinterface

// File: rtl/psum_lane_fifo.sv
// Single-lane synchronous FIFO with flush; head is the oldest entry.
module psum_lane_fifo
  import psum_row_pkg::*;
#(
  parameter int W     = PSUM_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/psum_row_collector.sv
// Per-lane FIFOs feeding a row output register; emits a row once every enabled lane has data.
// Optional partial-row timeout enabled by defining PSUM_ROW_TIMEOUT_EN.
module psum_row_collector
  import psum_row_pkg::*;
#(
  parameter int PU_ROW_LEN     = 16,
  parameter int PSUM_W         = PSUM_W_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush_i,
  input  logic [PU_ROW_LEN-1:0]   lane_enable_i,
  input  logic [PSUM_W-1:0]       psum_data_i [PU_ROW_LEN],
  input  logic [PU_ROW_LEN-1:0]   psum_valid_i,
  output logic [PU_ROW_LEN-1:0]   psum_stall_o,
  psum_row_collector_if.master    icm,
  output logic [ROWS_W-1:0]       rows_sent_o,
  output logic                    overflow_o,
  output logic                    timeout_o
);
  logic [PU_ROW_LEN-1:0] lane_full, lane_empty, lane_push, pending, pop_mask;
  logic [PSUM_W-1:0]     lane_head [PU_ROW_LEN];
  logic                  row_ready, tmo_fire, load, xfer;

  row_state_t            state_q, state_d;
  logic [PSUM_W-1:0]     wdata_q [PU_ROW_LEN];
  logic [PSUM_W-1:0]     wdata_d [PU_ROW_LEN];
  logic [PU_ROW_LEN-1:0] wen_q, wen_d;
  logic [ROWS_W-1:0]     rows_q, rows_d;
  logic                  ovf_q, ovf_d;

  assign lane_push = psum_valid_i & lane_enable_i & ~lane_full;
  assign pending   = lane_enable_i & ~lane_empty;
  assign row_ready = (|lane_enable_i) && ((lane_enable_i & lane_empty) == '0);

  for (genvar i = 0; i < PU_ROW_LEN; i++) begin : g_lane
    psum_lane_fifo #(.W(PSUM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush_i (flush_i),
      .push_i  (lane_push[i]),
      .pop_i   (pop_mask[i]),
      .din_i   (psum_data_i[i]),
      .full_o  (lane_full[i]),
      .empty_o (lane_empty[i]),
      .head_o  (lane_head[i])
    );
  end

`ifdef PSUM_ROW_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          tmo_q, tmo_d, waiting;

  // Counts only while a partial row sits idle; any progress restarts it.
  always_comb begin
    waiting  = (state_q == ST_IDLE) && (|pending) && !row_ready;
    tmo_fire = waiting && (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
    tcnt_d   = (waiting && !tmo_fire && !flush_i) ? tcnt_q + CW'(1) : '0;
    tmo_d    = tmo_fire && !flush_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    rows_d   = rows_q;
    ovf_d    = ovf_q | (|(psum_valid_i & lane_enable_i & lane_full));
    pop_mask = '0;
    load     = 1'b0;
    xfer     = (state_q == ST_SEND) && !icm.waitreq;
    if (xfer) rows_d = rows_q + ROWS_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (row_ready) begin
          load     = 1'b1;
          pop_mask = lane_enable_i;
        end else if (tmo_fire) begin
          load     = 1'b1;
          pop_mask = pending;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (row_ready) begin
            load     = 1'b1;
            pop_mask = lane_enable_i;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = ST_SEND;
      wen_d   = pop_mask;
      for (int i = 0; i < PU_ROW_LEN; i++)
        wdata_d[i] = pop_mask[i] ? lane_head[i] : '0;
    end
    // Flush abandons any pending row but keeps the statistics.
    if (flush_i) begin
      state_d  = ST_IDLE;
      wen_d    = '0;
      pop_mask = '0;
      for (int i = 0; i < PU_ROW_LEN; i++) wdata_d[i] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wen_q   <= '0;
      rows_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < PU_ROW_LEN; i++) wdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      rows_q  <= rows_d;
      ovf_q   <= ovf_d;
      wdata_q <= wdata_d;
    end
  end

  assign psum_stall_o   = lane_full;
  assign icm.writedata  = wdata_q;
  assign icm.cs         = (state_q == ST_SEND);
  assign icm.wordenable = wen_q;
  assign rows_sent_o    = rows_q;
  assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_psum_row_collector.sv
// Directed bench for psum_row_collector with a row scoreboard checked on each accepted transfer.
module tb_psum_row_collector;
  import psum_row_pkg::*;

  typedef struct {
    logic [159:0] data;
    logic [3:0]   wen;
  } row_t;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [3:0]  en, valid, stall;
  psum_word_t  data [4];
  logic [15:0] rows;
  logic        ovf, tmo;
  int          checks = 0;
  int          errors = 0;
  int          exp_rows = 0;
  row_t        sb [$];

  psum_row_collector_if #(.PU_ROW_LEN(4), .PSUM_W(40)) icm ();

  psum_row_collector #(
    .PU_ROW_LEN(4), .PSUM_W(40), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock         (clk),
    .reset         (reset),
    .flush_i       (flush),
    .lane_enable_i (en),
    .psum_data_i   (data),
    .psum_valid_i  (valid),
    .psum_stall_o  (stall),
    .icm           (icm),
    .rows_sent_o   (rows),
    .overflow_o    (ovf),
    .timeout_o     (tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] pk();
    return {icm.writedata[3], icm.writedata[2], icm.writedata[1], icm.writedata[0]};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [39:0] d0, input logic [39:0] d1,
                       input logic [39:0] d2, input logic [39:0] d3);
    valid   = v;
    data[0] = d0;
    data[1] = d1;
    data[2] = d2;
    data[3] = d3;
  endtask

  task automatic expect_row(input logic [159:0] d, input logic [3:0] w);
    row_t r;
    r.data = d;
    r.wen  = w;
    sb.push_back(r);
  endtask

  // Every accepted transfer must match the oldest expected row.
  always @(negedge clk) begin
    if (!reset && icm.cs && !icm.waitreq) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_row: observed data %0h expected no transfer", pk());
      end
      if (sb.size() != 0) begin
        row_t r;
        r = sb.pop_front();
        chk("row_data", pk(), r.data);
        chk("row_wen", icm.wordenable, r.wen);
      end
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    en    = 4'b1111;
    icm.waitreq = 1'b0;
    drive(4'b0000, 0, 0, 0, 0);
    step();
    step();
    chk("rst_stall", stall, 0);
    chk("rst_cs", icm.cs, 0);
    chk("rst_wen", icm.wordenable, 0);
    chk("rst_data", pk(), 0);
    chk("rst_rows", rows, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tmo", tmo, 0);
    reset = 1'b0;

    // Aligned lanes, two rows back to back
    step(); drive(4'b1111, 1, 2, 3, 4);
    expect_row({40'd4, 40'd3, 40'd2, 40'd1}, 4'b1111);
    step(); chk("al_cs_t1", icm.cs, 0);
    drive(4'b1111, 5, 6, 7, 8);
    expect_row({40'd8, 40'd7, 40'd6, 40'd5}, 4'b1111);
    step(); drive(4'b0000, 0, 0, 0, 0);
    chk("al_cs_t2", icm.cs, 1);
    chk("al_wen_t2", icm.wordenable, 4'b1111);
    step(); chk("al_cs_t3", icm.cs, 1);
    chk("al_rows_t3", rows, 1);
    step(); chk("al_cs_t4", icm.cs, 0);
    exp_rows = 2;
    chk("al_rows_t4", rows, exp_rows);

    // Skewed lanes with three cycles of backpressure
    step(); drive(4'b0001, 10, 0, 0, 0);
    expect_row({40'd13, 40'd12, 40'd11, 40'd10}, 4'b1111);
    step(); drive(4'b0010, 0, 11, 0, 0);
    step(); drive(4'b0100, 0, 0, 12, 0);
    step(); drive(4'b0000, 0, 0, 0, 0);
    step();
    step(); drive(4'b1000, 0, 0, 0, 13);
    icm.waitreq = 1'b1;
    step(); drive(4'b0000, 0, 0, 0, 0);
    chk("sk_cs_t6", icm.cs, 0);
    for (int c = 7; c <= 9; c++) begin
      step();
      chk("sk_cs_hold", icm.cs, 1);
      chk("sk_data_hold", pk(), {40'd13, 40'd12, 40'd11, 40'd10});
      chk("sk_wen_hold", icm.wordenable, 4'b1111);
      chk("sk_rows_hold", rows, exp_rows);
    end
    step(); chk("sk_cs_t10", icm.cs, 1);
    icm.waitreq = 1'b0;
    step(); chk("sk_cs_t11", icm.cs, 0);
    exp_rows = 3;
    chk("sk_rows", rows, exp_rows);

    // Disabled lanes 1 and 3
    en = 4'b0101;
    step(); drive(4'b1111, 50, 51, 52, 53);
    expect_row({40'd0, 40'd52, 40'd0, 40'd50}, 4'b0101);
    step(); drive(4'b0010, 0, 61, 0, 0);
    step(); drive(4'b0010, 0, 62, 0, 0);
    chk("dis_cs", icm.cs, 1);
    chk("dis_wen", icm.wordenable, 4'b0101);
    step(); drive(4'b0010, 0, 63, 0, 0);
    exp_rows = 4;
    chk("dis_rows", rows, exp_rows);
    step(); drive(4'b0010, 0, 64, 0, 0);
    step(); drive(4'b0000, 0, 0, 0, 0);
    chk("dis_ovf", ovf, 0);
    chk("dis_stall", stall, 0);
    chk("dis_cs_idle", icm.cs, 0);
    en = 4'b1111;

    // Overflow on lane 0
    step(); drive(4'b0001, 20, 0, 0, 0);
    step(); drive(4'b0001, 21, 0, 0, 0);
    step(); drive(4'b0001, 22, 0, 0, 0);
    step(); drive(4'b0001, 23, 0, 0, 0);
    chk("ov_stall_t3", stall, 0);
    step(); drive(4'b0001, 24, 0, 0, 0);
    chk("ov_stall_t4", stall, 4'b0001);
    chk("ov_ovf_t4", ovf, 0);
    step(); drive(4'b0000, 0, 0, 0, 0);
    chk("ov_ovf_t5", ovf, 1);
    chk("ov_stall_t5", stall, 4'b0001);
    chk("ov_cs_t5", icm.cs, 0);

    // Flush while a row is stalled in SEND
    icm.waitreq = 1'b1;
    step(); drive(4'b1110, 0, 31, 32, 33);
    step(); drive(4'b0001, 24, 0, 0, 0);
    chk("fl_stall_t1", stall, 4'b0001);
    chk("fl_cs_t1", icm.cs, 0);
    step(); drive(4'b0001, 25, 0, 0, 0);
    chk("fl_cs_t2", icm.cs, 1);
    chk("fl_data_t2", pk(), {40'd33, 40'd32, 40'd31, 40'd20});
    chk("fl_stall_t2", stall, 4'b0000);
    step(); drive(4'b0000, 0, 0, 0, 0);
    chk("fl_stall_t3", stall, 4'b0001);
    chk("fl_cs_t3", icm.cs, 1);
    flush = 1'b1;
    step(); flush = 1'b0;
    icm.waitreq = 1'b0;
    chk("fl_cs_t4", icm.cs, 0);
    chk("fl_stall_t4", stall, 0);
    chk("fl_wen_t4", icm.wordenable, 0);
    chk("fl_data_t4", pk(), 0);
    chk("fl_rows_t4", rows, exp_rows);
    chk("fl_ovf_t4", ovf, 1);

    // Lone lane 2: partial row only with the timeout option
    step(); drive(4'b0100, 0, 0, 60, 0);
`ifdef PSUM_ROW_TIMEOUT_EN
    expect_row({40'd0, 40'd60, 40'd0, 40'd0}, 4'b0100);
`endif
    step(); drive(4'b0000, 0, 0, 0, 0);
    repeat (7) step();
    chk("to_cs_t8", icm.cs, 0);
    chk("to_tmo_t8", tmo, 0);
    step();
`ifdef PSUM_ROW_TIMEOUT_EN
    chk("to_cs_t9", icm.cs, 1);
    chk("to_wen_t9", icm.wordenable, 4'b0100);
    chk("to_tmo_t9", tmo, 1);
    exp_rows = 5;
`else
    chk("to_cs_t9", icm.cs, 0);
    chk("to_tmo_t9", tmo, 0);
`endif
    step();
    chk("to_tmo_t10", tmo, 0);
    chk("to_cs_t10", icm.cs, 0);
    chk("to_rows_t10", rows, exp_rows);
    flush = 1'b1;
    step(); flush = 1'b0;
    step();
    chk("sb_empty", sb.size(), 0);
    chk("end_ovf", ovf, 1);

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst2_rows", rows, 0);
    chk("rst2_ovf", ovf, 0);
    chk("rst2_cs", icm.cs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
